dff16_window_unloader: RTL and testbench
========================================

Name: dff16_window_unloader

Overview:
- Return path of the 32-tap 16-bit sample window.
- On a load pulse it snapshots a full 32-word parallel window, then streams the words out serially, oldest tap first, under a valid/ready handshake.
- Feeding its output stream, beat by beat, into a data_valid-gated 32-deep shift chain reproduces the original tap contents exactly.
- Sits between the window/filter datapath and any serial consumer: readback, debug capture, next stage.

Parameters:
- DEPTH, 32, number of window words (taps); counter width is log2(DEPTH).
- WIDTH, 16, bits per word; words are two's-complement but passed through unmodified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: asserting rst low resets immediately, regardless of clk.
- load  input  1  snapshot request; sampled only when busy==0.
- win  input  DEPTH*WIDTH  parallel window; tap k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k]; tap 0 is newest, tap DEPTH-1 is oldest.
- dout  output  WIDTH  current serial word (registered).
- dout_valid  output  1  dout holds a word for transfer (registered).
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  high from snapshot until the final beat is accepted (registered).
- done  output  1  single-cycle pulse after the final beat (registered).

Behaviour:
- Reset (rst low, async): state IDLE; dout=0, dout_valid=0, busy=0, done=0; snapshot buffer and index cleared. Reset mid-stream aborts the stream with no done pulse. Operation resumes on the first rising clk edge after rst goes high.
- Beat: a rising edge with dout_valid==1 and dout_ready==1.
- States:
  - IDLE: busy=0, dout_valid=0. On an edge with load==1, the block captures all of win into the buffer, sets idx=DEPTH-1, and enters SEND. Cycle after: dout=tap DEPTH-1, dout_valid=1, busy=1. Latency from load edge to first valid word = 1 cycle.
  - SEND: dout = buffer[idx] and is held stable while dout_valid && !dout_ready (no change, no skipped or duplicated words).
    - On a beat with idx>0: idx decrements and dout updates to the next word in the following cycle. Back-to-back beats give 1 word/cycle.
    - On a beat with idx==0: enter IDLE; the next cycle has dout_valid=0, busy=0, done=1 (one cycle only), and dout returns to 0.
- Output order: tap DEPTH-1, DEPTH-2, ..., 0. Exactly DEPTH beats per load.
- load while busy==1 is ignored: no restart, buffer untouched.
- load during the done cycle is accepted, because busy==0 in that cycle. The minimum gap between streams is therefore 1 idle cycle.
- win changes after the capture edge have no effect on the current stream.
- dout_ready while dout_valid==0 is ignored.
- Arithmetic: idx is an unsigned down-counter with no wrap. It never decrements below 0.
- No combinational path from dout_ready or load to any output.

Test Plan:
- Basic stream: reset, win tap k = 16'h0100+k, load 1 cycle, dout_ready=1 constantly. Required: first beat 16'h011F one cycle after load; then 32 consecutive beats 16'h011F down to 16'h0100; done high for exactly 1 cycle after beat 32; busy high for exactly 32 cycles.
- Backpressure: same window, dout_ready toggled 1,0,0,1 repeating. Required: dout/dout_valid stable during stalls; the 32 words arrive in the same order with no loss or duplication; done only after the final accepted beat.
- Ignored load/win change: during the stream pulse load with win all 16'hFFFF. Required: the stream continues with the original values and finishes after 32 beats; no restart.
- Round trip: pipe dout/dout_valid&&dout_ready into a 32-tap data_valid shift chain, with signed taps including 16'h8000 and 16'h7FFF. Required: after done, chain taps 0..31 equal the original win taps bit-exactly.
- Reset mid-stream: drive rst low after beat 10. Required: dout_valid, busy, done and dout drop to 0 immediately without a clock edge. After release, load with a new window restarts from tap 31.
- Reload at done: assert load in the done cycle. Required: the new window is captured and its first word is valid one cycle later.

Source files
------------

// File: rtl/dff16_window_unloader.sv
// dff16_window_unloader: snapshots a parallel tap window on load and
// streams it out oldest tap first over a valid/ready handshake.
module dff16_window_unloader #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] win,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] snap [DEPTH];
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_dn;

    // Index of the word that follows the one currently on dout.
    always_comb begin
        idx_dn = idx - IW'(1);
    end

    // Snapshot capture and oldest-first serial drain with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            snap[k] <= win[WIDTH*k +: WIDTH];
                        end
                        idx        <= IW'(DEPTH - 1);
                        dout       <= win[WIDTH*(DEPTH-1) +: WIDTH];
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        if (idx != '0) begin
                            idx  <= idx_dn;
                            dout <= snap[idx_dn];
                        end else begin
                            state      <= IDLE;
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff16_window_unloader.sv
// tb_dff16_window_unloader: randomized self-checking bench comparing the
// serial stream against a queue of window taps taken oldest first.
module tb_dff16_window_unloader;

    localparam int DEPTH = 32;
    localparam int WIDTH = 16;

    logic                   clk;
    logic                   rst;
    logic                   load;
    logic [DEPTH*WIDTH-1:0] win;
    logic [WIDTH-1:0]       dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   busy;
    logic                   done;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] got [$];
    logic [WIDTH-1:0] orig [DEPTH];
    logic [WIDTH-1:0] chain [DEPTH];
    int busy_cycles;
    int stall_bad;
    int done_cnt;
    int done_at;
    bit to_flag;

    dff16_window_unloader #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .win       (win),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer-side shift chain: newest accepted word enters tap 0.
    always @(posedge clk) begin
        if (dout_valid && dout_ready) begin
            for (int k = DEPTH - 1; k > 0; k--) chain[k] <= chain[k-1];
            chain[0] <= dout;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected stream: taps DEPTH-1 down to 0 of the current window.
    task automatic build_exp;
        exp_q.delete();
        for (int k = DEPTH - 1; k >= 0; k--) begin
            exp_q.push_back(win[WIDTH*k +: WIDTH]);
            orig[k] = win[WIDTH*k +: WIDTH];
        end
    endtask

    task automatic rand_win;
        for (int k = 0; k < DEPTH; k++) win[WIDTH*k +: WIDTH] = 16'($urandom());
    endtask

    task automatic start_load;
        load = 1'b1;
        tick;
        load = 1'b0;
    endtask

    // Drives dout_ready per pattern and records what the consumer sees.
    task automatic collect(input int pat, input int poke_at, input bit stop_at_done);
        logic pv, pr;
        logic [WIDTH-1:0] pd;
        got.delete();
        busy_cycles = 0; stall_bad = 0; done_cnt = 0; done_at = -1;
        to_flag = 1'b1; pv = 1'b0; pr = 1'b0; pd = '0;
        for (int c = 0; c < 2000; c++) begin
            if (busy === 1'b1) busy_cycles++;
            if (pv && !pr && (dout_valid !== 1'b1 || dout !== pd)) stall_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = got.size();
                load = 1'b0;
                to_flag = 1'b0;
                if (!stop_at_done) begin
                    tick;
                    if (done === 1'b1) done_cnt++;
                end
                return;
            end
            load = (c == poke_at);
            if (c == poke_at) win = '1;
            case (pat)
                0: dout_ready = 1'b1;
                1: dout_ready = (c % 4 == 0) || (c % 4 == 3);
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (dout_valid === 1'b1 && dout_ready) got.push_back(dout);
            pv = dout_valid; pr = dout_ready; pd = dout;
            tick;
        end
        load = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({dout_valid, busy, done} !== 3'b000 || dout !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b b=%b d=%b dout=%h want 0", dout_valid, busy, done, dout);
        end
        tick;
        tick;
        rst = 1'b1;
        tick;
        n_checks++;
        if ({dout_valid, busy, done} !== 3'b000 || dout !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b b=%b d=%b dout=%h want 0", dout_valid, busy, done, dout);
        end
    endtask

    task automatic test_basic;
        for (int k = 0; k < DEPTH; k++) win[WIDTH*k +: WIDTH] = 16'h0100 + 16'(k);
        build_exp();
        start_load();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 16'h011F || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first: got v=%b dout=%h busy=%b want 1 011f 1", dout_valid, dout, busy);
        end
        collect(0, -1, 1'b0);
        n_checks++;
        if (to_flag || got.size() != DEPTH) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats timeout=%0d want %0d", got.size(), to_flag, DEPTH);
        end
        for (int i = 0; i < got.size() && i < DEPTH; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (busy_cycles != DEPTH) begin
            n_fail++;
            $display("FAIL basic_busy: got %0d cycles want %0d", busy_cycles, DEPTH);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != DEPTH) begin
            n_fail++;
            $display("FAIL basic_done: got cnt=%0d at=%0d want 1 at %0d", done_cnt, done_at, DEPTH);
        end
        n_checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL basic_idle: got v=%b b=%b dout=%h want 0 0 0", dout_valid, busy, dout);
        end
    endtask

    task automatic test_backpressure;
        rand_win();
        build_exp();
        start_load();
        collect(1, -1, 1'b0);
        n_checks++;
        if (to_flag || stall_bad != 0) begin
            n_fail++;
            $display("FAIL bp_stall: got %0d unstable stalls timeout=%0d want 0", stall_bad, to_flag);
        end
        n_checks++;
        if (got != exp_q) begin
            n_fail++;
            $display("FAIL bp_order: got %0d words first=%h want %0d first=%h", got.size(), got.size() ? got[0] : 16'h0, exp_q.size(), exp_q[0]);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != DEPTH) begin
            n_fail++;
            $display("FAIL bp_done: got cnt=%0d at=%0d want 1 at %0d", done_cnt, done_at, DEPTH);
        end
    endtask

    task automatic test_ignored_load;
        rand_win();
        build_exp();
        start_load();
        collect(2, 5, 1'b0);
        n_checks++;
        if (to_flag || got != exp_q) begin
            n_fail++;
            $display("FAIL ignload_stream: got %0d words timeout=%0d want %0d original", got.size(), to_flag, DEPTH);
        end
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignload_end: got done=%0d busy=%b v=%b want 1 0 0", done_cnt, busy, dout_valid);
        end
    endtask

    task automatic test_round_trip;
        rand_win();
        win[WIDTH*3 +: WIDTH] = 16'h8000;
        win[WIDTH*17 +: WIDTH] = 16'h7FFF;
        win[WIDTH*31 +: WIDTH] = 16'h8000;
        win[WIDTH*0 +: WIDTH] = 16'h7FFF;
        build_exp();
        start_load();
        collect(2, -1, 1'b0);
        n_checks++;
        if (to_flag || done_cnt != 1) begin
            n_fail++;
            $display("FAIL rt_done: got done=%0d timeout=%0d want 1 0", done_cnt, to_flag);
        end
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (chain[k] !== orig[k]) begin
                n_fail++;
                $display("FAIL rt_tap%0d: got %h want %h", k, chain[k], orig[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        rand_win();
        start_load();
        for (int i = 0; i < 10; i++) begin
            dout_ready = 1'b1;
            tick;
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({dout_valid, busy, done} !== 3'b000 || dout !== '0) begin
            n_fail++;
            $display("FAIL rmid_async: got v=%b b=%b d=%b dout=%h want 0", dout_valid, busy, done, dout);
        end
        tick;
        tick;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_hold: got done=%b busy=%b want 0 0", done, busy);
        end
        rst = 1'b1;
        tick;
        rand_win();
        build_exp();
        start_load();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rmid_restart: got v=%b dout=%h want 1 %h", dout_valid, dout, exp_q[0]);
        end
        collect(2, -1, 1'b0);
        n_checks++;
        if (to_flag || got != exp_q) begin
            n_fail++;
            $display("FAIL rmid_stream: got %0d words timeout=%0d want %0d", got.size(), to_flag, DEPTH);
        end
    endtask

    task automatic test_back_to_back;
        rand_win();
        build_exp();
        start_load();
        collect(0, -1, 1'b1);
        n_checks++;
        if (to_flag || got != exp_q || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d words done=%b busy=%b want %0d 1 0", got.size(), done, busy, DEPTH);
        end
        rand_win();
        build_exp();
        start_load();
        n_checks++;
        if (dout_valid !== 1'b1 || busy !== 1'b1 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_reload: got v=%b b=%b dout=%h want 1 1 %h", dout_valid, busy, dout, exp_q[0]);
        end
        collect(2, -1, 1'b0);
        n_checks++;
        if (to_flag || got != exp_q || done_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d words done=%0d want %0d 1", got.size(), done_cnt, DEPTH);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        load = 1'b0;
        win = '0;
        dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_load();
        test_round_trip();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
